divider: RTL and testbench

- Sequential unsigned restoring divider. It is the inverse of the existing shift-add multiplier.
- Takes a 2N-bit dividend and an N-bit divisor. Produces an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Uses the same start/finished handshake as the multiplier, so a product can be fed straight back for round-trip checking.
- Sits beside the multiplier in the arithmetic unit and gets its own bench wrapper, which dumps to divider.vcd.

---
 rtl/divider_pkg.sv | 21 ++
 rtl/divider_step.sv | 40 ++++
 rtl/divider.sv | 153 +++++++++++++++
 tb/tb_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared arithmetic-unit definitions. The divider and the shift-add
// multiplier's controller both use these.
//   - Controller state encoding (IDLE / DIVIDE / DONE). The multiplier's
//     controller uses the same encoding.
//   - cnt_width(): width of the per-bit iteration counter for an N-bit operand.
// No ports (package).
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // The counter runs from n-1 down to 0, so clog2(n) bits are enough (n >= 2).
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational iteration of unsigned restoring division.
// The logic shifts the partial remainder left and shifts in the next dividend
// bit. It then subtracts the divisor when the divisor fits.
//   i_rem      in  N+1  current partial remainder
//   i_q_msb    in  1    next dividend/quotient bit to shift in
//   i_divisor  in  N    divisor
//   o_rem      out N+1  new partial remainder
//   o_q_bit    out 1    quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module divider_step #(
    parameter int N = 4
) (
    input  logic [N:0]   i_rem,
    input  logic         i_q_msb,
    input  logic [N-1:0] i_divisor,
    output logic [N:0]   o_rem,
    output logic         o_q_bit
);

    logic [N:0] shifted;
    logic [N:0] divisor_ext;

    // The compare and the subtract are N+1 bits wide. Shifting out the top bit
    // of the remainder therefore cannot wrap.
    assign divisor_ext = {1'b0, i_divisor};

    always_comb begin
        shifted = {i_rem[N-1:0], i_q_msb};
        if (shifted >= divisor_ext) begin
            o_rem   = shifted - divisor_ext;
            o_q_bit = 1'b1;
        end else begin
            o_rem   = shifted;
            o_q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Sequential unsigned restoring divider that produces one quotient bit per
// clock. The block inverts the shift-add multiplier and uses the same
// start/finished handshake.
//   i_clock      in  1   clock, rising edge
//   i_reset      in  1   asynchronous active-low reset
//   i_start      in  1   start request, sampled in IDLE or DONE only
//   i_dividend   in  2N  unsigned dividend
//   i_divisor    in  N   unsigned divisor
//   o_finished   out 1   results valid (DONE)
//   o_error      out 1   divide by zero or quotient overflow (valid in DONE)
//   o_quotient   out N   unsigned quotient
//   o_remainder  out N   unsigned remainder
// Normal latency: o_finished rises N edges after the edge that samples start.
// An invalid request flags an error one edge after that edge.
// -----------------------------------------------------------------------------
module divider
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [2*N-1:0] i_dividend,
    input  logic [N-1:0]   i_divisor,
    output logic           o_finished,
    output logic           o_error,
    output logic [N-1:0]   o_quotient,
    output logic [N-1:0]   o_remainder
);

    localparam int              CW       = cnt_width(N);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

    logic [1:0]    state_q,     state_d;
    logic [N:0]    rem_q,       rem_d;
    logic [N-1:0]  work_q,      work_d;
    logic [N-1:0]  divisor_q,   divisor_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          err_pend_q,  err_pend_d;
    logic          finished_q,  finished_d;
    logic          error_q,     error_d;
    logic [N-1:0]  quotient_q,  quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;

    logic [N:0]    step_rem;
    logic          step_bit;
    logic          start_err;

    divider_step #(.N(N)) u_step (
        .i_rem     (rem_q),
        .i_q_msb   (work_q[N-1]),
        .i_divisor (divisor_q),
        .o_rem     (step_rem),
        .o_q_bit   (step_bit)
    );

    // If the high half of the dividend is not below the divisor, the quotient
    // cannot fit in N bits. A zero divisor also satisfies this compare, but the
    // zero check stays explicit because that case is the one readers look for.
    assign start_err = (i_divisor == '0) || (i_dividend[2*N-1:N] >= i_divisor);

    always_comb begin
        // NOTE: every *_d defaults to its flop value first. A branch that does
        // not assign a signal then holds that signal instead of inferring a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        work_d      = work_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;
        err_pend_d  = err_pend_q;
        finished_d  = finished_q;
        error_d     = error_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    divisor_d   = i_divisor;
                    rem_d       = {1'b0, i_dividend[2*N-1:N]};
                    work_d      = i_dividend[N-1:0];
                    cnt_d       = CNT_LAST;
                    err_pend_d  = start_err;
                    finished_d  = 1'b0;
                    error_d     = 1'b0;
                    quotient_d  = '0;
                    remainder_d = '0;
                    state_d     = ST_DIVIDE;
                end
            end

            ST_DIVIDE: begin
                if (err_pend_q) begin
                    // An invalid request spends one edge in DIVIDE and then
                    // reports with zeroed results.
                    err_pend_d = 1'b0;
                    finished_d = 1'b1;
                    error_d    = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    rem_d  = step_rem;
                    work_d = {work_q[N-2:0], step_bit};
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        finished_d  = 1'b1;
                        quotient_d  = {work_q[N-2:0], step_bit};
                        remainder_d = step_rem[N-1:0];
                        state_d     = ST_DONE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together from values computed in the previous cycle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            work_q      <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            err_pend_q  <= 1'b0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            work_q      <= work_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
            err_pend_q  <= err_pend_d;
            finished_q  <= finished_d;
            error_q     <= error_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign o_finished  = finished_q;
    assign o_error     = error_q;
    assign o_quotient  = quotient_q;
    assign o_remainder = remainder_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Self-checking bench for divider with N = 4. A vector table runs
// back-to-back operations. Each start pushes its expected result to a
// scoreboard queue. The expected entry is popped when o_finished rises.
// Hand-written sequences cover reset, DONE hold, start pulses during DIVIDE,
// and abort by reset.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_divider;

    localparam int N     = 4;
    localparam int LIMIT = 20;

    logic           i_clock = 1'b0;
    logic           i_reset;
    logic           i_start;
    logic [2*N-1:0] i_dividend;
    logic [N-1:0]   i_divisor;
    logic           o_finished;
    logic           o_error;
    logic [N-1:0]   o_quotient;
    logic [N-1:0]   o_remainder;

    divider #(.N(N)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_finished  (o_finished),
        .o_error     (o_error),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [2*N-1:0] dvd;
        logic [N-1:0]   dvs;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           err;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge. poke pulses i_start with junk operands
    // during DIVIDE, and the DUT must ignore that pulse.
    task automatic run_op(input string tag, input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                          input logic [N-1:0] q, input logic [N-1:0] r, input logic err,
                          input bit poke);
        exp_t e;
        int   k;
        bit   done;
        e.q   = q;
        e.r   = r;
        e.err = err;
        e.lat = err ? 1 : N;
        sb.push_back(e);

        i_dividend = dvd;
        i_divisor  = dvs;
        i_start    = 1'b1;
        @(posedge i_clock);
        @(negedge i_clock);
        i_start = 1'b0;

        k    = 0;
        done = 1'b0;
        while (!done && k < LIMIT) begin
            @(posedge i_clock);
            k++;
            @(negedge i_clock);
            if (o_finished) done = 1'b1;
            if (poke && k == 1) begin
                i_start    = 1'b1;
                i_dividend = 8'hff;
                i_divisor  = '0;
            end else if (poke && k == 2) begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;

        e = sb.pop_front();
        check({tag, " latency"}, done ? k : -1, e.lat);
        check({tag, " error"},     o_error,     e.err);
        check({tag, " quotient"},  o_quotient,  e.q);
        check({tag, " remainder"}, o_remainder, e.r);
    endtask

    vec_t vecs[$];

    initial begin
        bit seen;

        vecs = '{
            '{dvd: 8'd143, dvs: 4'd11, q: 4'd13, r: 4'd0,  err: 1'b0},
            '{dvd: 8'd100, dvs: 4'd7,  q: 4'd14, r: 4'd2,  err: 1'b0},
            '{dvd: 8'd50,  dvs: 4'd0,  q: 4'd0,  r: 4'd0,  err: 1'b1},
            '{dvd: 8'd200, dvs: 4'd3,  q: 4'd0,  r: 4'd0,  err: 1'b1},
            '{dvd: 8'd225, dvs: 4'd15, q: 4'd15, r: 4'd0,  err: 1'b0},
            '{dvd: 8'd0,   dvs: 4'd5,  q: 4'd0,  r: 4'd0,  err: 1'b0},
            '{dvd: 8'd117, dvs: 4'd13, q: 4'd9,  r: 4'd0,  err: 1'b0},
            '{dvd: 8'd255, dvs: 4'd15, q: 4'd0,  r: 4'd0,  err: 1'b1},
            '{dvd: 8'd16,  dvs: 4'd1,  q: 4'd0,  r: 4'd0,  err: 1'b1},
            '{dvd: 8'd1,   dvs: 4'd1,  q: 4'd1,  r: 4'd0,  err: 1'b0},
            '{dvd: 8'd15,  dvs: 4'd2,  q: 4'd7,  r: 4'd1,  err: 1'b0},
            '{dvd: 8'd239, dvs: 4'd15, q: 4'd15, r: 4'd14, err: 1'b0}
        };

        // Reset state.
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        #1;
        check("reset finished",  o_finished,  0);
        check("reset error",     o_error,     0);
        check("reset quotient",  o_quotient,  0);
        check("reset remainder", o_remainder, 0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;

        // Idle with start low: nothing happens.
        i_dividend = 8'd143;
        i_divisor  = 4'd11;
        seen = 1'b0;
        repeat (N + 2) begin
            @(negedge i_clock);
            if (o_finished) seen = 1'b1;
        end
        check("idle no finish", seen, 0);

        // Table: every operation after the first starts directly from DONE.
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
                   vecs[i].err, 1'b0);

        // DONE holds for 3 cycles with start low.
        run_op("hold", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge i_clock);
            check("hold finished",  o_finished,  1);
            check("hold quotient",  o_quotient,  14);
            check("hold remainder", o_remainder, 2);
        end

        // A start pulse and operand changes during DIVIDE are ignored.
        run_op("poke", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b1);

        // Reset while in DONE clears the results immediately.
        run_op("pre-reset", 8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0);
        i_reset = 1'b0;
        #1;
        check("done-reset finished",  o_finished,  0);
        check("done-reset quotient",  o_quotient,  0);
        check("done-reset remainder", o_remainder, 0);
        @(negedge i_clock);
        i_reset = 1'b1;

        // Reset two edges into an operation aborts it.
        i_dividend = 8'd143;
        i_divisor  = 4'd11;
        i_start    = 1'b1;
        @(posedge i_clock);
        @(negedge i_clock);
        i_start = 1'b0;
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        check("abort finished",  o_finished,  0);
        check("abort error",     o_error,     0);
        check("abort quotient",  o_quotient,  0);
        check("abort remainder", o_remainder, 0);
        @(negedge i_clock);
        i_reset = 1'b1;
        seen = 1'b0;
        repeat (N + 2) begin
            @(negedge i_clock);
            if (o_finished) seen = 1'b1;
        end
        check("abort no finish", seen, 0);
        run_op("after-abort", 8'd143, 4'd11, 4'd13, 4'd0, 1'b0, 1'b0);

        check("scoreboard empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
